// File: rtl/stepper_phase_decoder.sv
// Receive-side monitor for the half-step coil drive: settles the 4-bit pattern,
// decodes the phase index and tracks position, direction, step period, stall and faults.
module stepper_phase_decoder #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] TIMEOUT       = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  stepper_signals,
    input  logic        clear_fault,
    output logic [2:0]  phase,
    output logic        phase_valid,
    output logic [7:0]  position,
    output logic        direction,
    output logic        step_pulse,
    output logic [15:0] period,
    output logic        period_valid,
    output logic        stalled,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

    localparam int             RW         = $clog2(SETTLE_CYCLES + 2);
    localparam logic [RW-1:0]  RUN_ACCEPT = RW'(SETTLE_CYCLES);
    localparam logic [RW-1:0]  RUN_DONE   = RW'(SETTLE_CYCLES + 1);

    state_t         state, state_n;
    logic [3:0]     in_q;
    logic [RW-1:0]  run_cnt;
    logic [15:0]    interval_cnt;
    logic           step_seen;

    logic           accept, clear_req, released, legal, lock, step_fwd, step_rev;
    logic [2:0]     idx, delta;
    logic [2:0]     phase_n;
    logic [7:0]     position_n;
    logic           direction_n;
    logic [1:0]     fault_code_n;

    assign phase_valid = (state == TRACK);
    assign fault       = (state == FAULT);

    assign accept    = (run_cnt == RUN_ACCEPT);
    assign clear_req = (state == FAULT) && clear_fault;

    always_comb begin
        idx      = '0;
        legal    = 1'b1;
        released = 1'b0;
        case (in_q)
            4'b1000: idx = 3'd0;
            4'b1100: idx = 3'd1;
            4'b0100: idx = 3'd2;
            4'b0110: idx = 3'd3;
            4'b0010: idx = 3'd4;
            4'b0011: idx = 3'd5;
            4'b0001: idx = 3'd6;
            4'b1001: idx = 3'd7;
            4'b0000: begin legal = 1'b0; released = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

    assign delta = idx - phase;

    always_comb begin
        state_n      = state;
        phase_n      = phase;
        position_n   = position;
        direction_n  = direction;
        fault_code_n = fault_code;
        lock         = 1'b0;
        step_fwd     = 1'b0;
        step_rev     = 1'b0;
        case (state)
            IDLE: if (accept && !released) begin
                if (legal) begin
                    state_n = TRACK;
                    phase_n = idx;
                    lock    = 1'b1;
                end else begin
                    state_n      = FAULT;
                    fault_code_n = 2'b01;
                end
            end
            TRACK: if (accept) begin
                if (released) begin
                    state_n = IDLE;
                end else if (!legal) begin
                    state_n      = FAULT;
                    fault_code_n = 2'b01;
                end else if (delta == 3'd1) begin
                    step_fwd    = 1'b1;
                    phase_n     = idx;
                    position_n  = position + 8'd1;
                    direction_n = 1'b1;
                end else if (delta == 3'd7) begin
                    step_rev    = 1'b1;
                    phase_n     = idx;
                    position_n  = position - 8'd1;
                    direction_n = 1'b0;
                end else if (delta != 3'd0) begin
                    state_n      = FAULT;
                    fault_code_n = 2'b10;
                end
            end
            FAULT: if (clear_fault) begin
                state_n      = IDLE;
                fault_code_n = 2'b00;
            end
            default: state_n = IDLE;
        endcase
    end

    // Run counter saturates one past the accept value so each run is accepted once;
    // clearing a fault restarts it so the held pattern is re-evaluated from IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q    <= '0;
            run_cnt <= '0;
        end else begin
            in_q <= stepper_signals;
            if (clear_req)
                run_cnt <= '0;
            else if (stepper_signals != in_q)
                run_cnt <= RW'(1);
            else if (run_cnt != RUN_DONE)
                run_cnt <= run_cnt + 1'b1;
        end
    end

    // One interval counter serves both period measurement and stall detection,
    // since both restart on every lock or step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            phase        <= '0;
            position     <= '0;
            direction    <= 1'b0;
            step_pulse   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
            fault_code   <= '0;
            interval_cnt <= '0;
            step_seen    <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            position   <= position_n;
            direction  <= direction_n;
            fault_code <= fault_code_n;
            step_pulse <= step_fwd || step_rev;

            if (lock || step_fwd || step_rev)
                interval_cnt <= 16'd1;
            else if (interval_cnt != 16'hFFFF)
                interval_cnt <= interval_cnt + 16'd1;

            if (step_fwd || step_rev)
                period <= interval_cnt;

            if (lock) begin
                step_seen    <= 1'b0;
                period_valid <= 1'b0;
            end else if (step_fwd || step_rev) begin
                step_seen <= 1'b1;
                if (step_seen)
                    period_valid <= 1'b1;
            end else if (state == TRACK && state_n == IDLE) begin
                period_valid <= 1'b0;
            end

            if (state_n != TRACK || step_fwd || step_rev)
                stalled <= 1'b0;
            else if (state == TRACK && interval_cnt == TIMEOUT)
                stalled <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Directed, table-driven bench for stepper_phase_decoder (SETTLE_CYCLES=2, TIMEOUT=20).
module tb_stepper_phase_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  stepper_signals;
    logic        clear_fault;
    logic [2:0]  phase;
    logic        phase_valid;
    logic [7:0]  position;
    logic        direction;
    logic        step_pulse;
    logic [15:0] period;
    logic        period_valid;
    logic        stalled;
    logic        fault;
    logic [1:0]  fault_code;

    int checks   = 0;
    int failures = 0;

    stepper_phase_decoder #(
        .SETTLE_CYCLES(2),
        .TIMEOUT(16'd20)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .stepper_signals(stepper_signals),
        .clear_fault(clear_fault),
        .phase(phase),
        .phase_valid(phase_valid),
        .position(position),
        .direction(direction),
        .step_pulse(step_pulse),
        .period(period),
        .period_valid(period_valid),
        .stalled(stalled),
        .fault(fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pat;
        logic        clr;
        int          hold;
        logic [2:0]  phase;
        logic        pv;
        logic [7:0]  pos;
        logic        dir;
        int          steps;
        logic        per_v;
        logic [15:0] per;
        logic        stall;
        logic        flt;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input int i);
        int pulses;
        pulses          = 0;
        stepper_signals = vecs[i].pat;
        clear_fault     = vecs[i].clr;
        for (int c = 0; c < vecs[i].hold; c++) begin
            @(posedge clk);
            #1;
            clear_fault = 1'b0;
            if (step_pulse) pulses++;
        end
        check($sformatf("v%0d.phase", i), 32'(phase), 32'(vecs[i].phase));
        check($sformatf("v%0d.phase_valid", i), 32'(phase_valid), 32'(vecs[i].pv));
        check($sformatf("v%0d.position", i), 32'(position), 32'(vecs[i].pos));
        check($sformatf("v%0d.direction", i), 32'(direction), 32'(vecs[i].dir));
        check($sformatf("v%0d.step_pulses", i), 32'(pulses), 32'(vecs[i].steps));
        check($sformatf("v%0d.period_valid", i), 32'(period_valid), 32'(vecs[i].per_v));
        check($sformatf("v%0d.period", i), 32'(period), 32'(vecs[i].per));
        check($sformatf("v%0d.stalled", i), 32'(stalled), 32'(vecs[i].stall));
        check($sformatf("v%0d.fault", i), 32'(fault), 32'(vecs[i].flt));
        check($sformatf("v%0d.fault_code", i), 32'(fault_code), 32'(vecs[i].code));
    endtask

    initial begin
        //          pat    clr hold ph   pv pos    dir st pv per     stl flt code
        vecs[0]  = '{4'b1000, 0, 5, 3'd0, 1, 8'h00, 0, 0, 0, 16'd0,  0, 0, 2'd0};
        vecs[1]  = '{4'b1100, 0, 4, 3'd1, 1, 8'h01, 1, 1, 0, 16'd5,  0, 0, 2'd0};
        vecs[2]  = '{4'b0100, 0, 4, 3'd2, 1, 8'h02, 1, 1, 1, 16'd4,  0, 0, 2'd0};
        vecs[3]  = '{4'b1100, 0, 4, 3'd1, 1, 8'h01, 0, 1, 1, 16'd4,  0, 0, 2'd0};
        vecs[4]  = '{4'b1000, 0, 4, 3'd0, 1, 8'h00, 0, 1, 1, 16'd4,  0, 0, 2'd0};
        vecs[5]  = '{4'b1001, 0, 4, 3'd7, 1, 8'hFF, 0, 1, 1, 16'd4,  0, 0, 2'd0};
        vecs[6]  = '{4'b1000, 0, 4, 3'd0, 1, 8'h00, 1, 1, 1, 16'd4,  0, 0, 2'd0};
        vecs[7]  = '{4'b1100, 0, 1, 3'd0, 1, 8'h00, 1, 0, 1, 16'd4,  0, 0, 2'd0};
        vecs[8]  = '{4'b1000, 0, 5, 3'd0, 1, 8'h00, 1, 0, 1, 16'd4,  0, 0, 2'd0};
        vecs[9]  = '{4'b0110, 0, 4, 3'd0, 0, 8'h00, 1, 0, 1, 16'd4,  0, 1, 2'd2};
        vecs[10] = '{4'b0110, 1, 5, 3'd3, 1, 8'h00, 1, 0, 0, 16'd4,  0, 0, 2'd0};
        vecs[11] = '{4'b0000, 0, 4, 3'd3, 0, 8'h00, 1, 0, 0, 16'd4,  0, 0, 2'd0};
        vecs[12] = '{4'b1010, 0, 4, 3'd3, 0, 8'h00, 1, 0, 0, 16'd4,  0, 1, 2'd1};
        vecs[13] = '{4'b0000, 1, 4, 3'd3, 0, 8'h00, 1, 0, 0, 16'd4,  0, 0, 2'd0};
        vecs[14] = '{4'b0010, 0, 5, 3'd4, 1, 8'h00, 1, 0, 0, 16'd4,  0, 0, 2'd0};
        vecs[15] = '{4'b0011, 1, 4, 3'd5, 1, 8'h01, 1, 1, 0, 16'd5,  0, 0, 2'd0};
        vecs[16] = '{4'b0001, 0, 4, 3'd6, 1, 8'h02, 1, 1, 1, 16'd23, 0, 0, 2'd0};
        vecs[17] = '{4'b0000, 0, 4, 3'd6, 0, 8'h02, 1, 0, 0, 16'd23, 0, 0, 2'd0};

        reset_n         = 1'b0;
        stepper_signals = 4'b0000;
        clear_fault     = 1'b0;
        tick(3);
        check("rst.phase", 32'(phase), 0);
        check("rst.phase_valid", 32'(phase_valid), 0);
        check("rst.position", 32'(position), 0);
        check("rst.direction", 32'(direction), 0);
        check("rst.step_pulse", 32'(step_pulse), 0);
        check("rst.period", 32'(period), 0);
        check("rst.period_valid", 32'(period_valid), 0);
        check("rst.stalled", 32'(stalled), 0);
        check("rst.fault", 32'(fault), 0);
        check("rst.fault_code", 32'(fault_code), 0);
        reset_n = 1'b1;

        for (int i = 0; i <= 15; i++) run_vec(i);

        // Stall: the step at v15 restarts the interval; stalled rises 20 edges later.
        tick(18);
        check("stall.before", 32'(stalled), 0);
        tick(1);
        check("stall.after", 32'(stalled), 1);

        for (int i = 16; i <= 17; i++) run_vec(i);

        // clear_fault coinciding with an acceptance wins, then relock from IDLE.
        stepper_signals = 4'b1010;
        tick(4);
        check("cbp.fault_in", 32'(fault), 1);
        check("cbp.code_in", 32'(fault_code), 1);
        stepper_signals = 4'b1000;
        tick(2);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        check("cbp.fault_out", 32'(fault), 0);
        check("cbp.code_out", 32'(fault_code), 0);
        check("cbp.pv_idle", 32'(phase_valid), 0);
        tick(2);
        check("cbp.pv_settling", 32'(phase_valid), 0);
        tick(1);
        check("cbp.pv_lock", 32'(phase_valid), 1);
        check("cbp.phase", 32'(phase), 0);
        check("cbp.position", 32'(position), 2);

        #2 reset_n = 1'b0;
        #1;
        check("arst.phase_valid", 32'(phase_valid), 0);
        check("arst.position", 32'(position), 0);
        check("arst.period", 32'(period), 0);
        check("arst.direction", 32'(direction), 0);
        tick(1);
        reset_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
